mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-master arbiter sharing one synchronous single-port RAM (1-cycle read latency, byte write enables).
- Master 0 is the picorv32 native memory port; master 1 is a secondary bus master (blitter/DMA) using the same valid/ready handshake.
- Sits between the CPU chip-select logic and a RAM instance. Lets a second engine access work RAM or VRAM without stalling the design on conflicts beyond one transaction.

Parameters:
- ADDR_WIDTH, 10, word address width presented to the RAM.
- DATA_WIDTH, 32, data width; the number of strobes is DATA_WIDTH/8.
- MAX_WAIT, 4, losing arbitrations master 1 tolerates before it is forced to win (fixed-priority mode only).
- CNT_WIDTH, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- m0_valid  in  1  master 0 request; held until m0_ready.
- m0_ready  out  1  master 0 completion strobe, one cycle.
- m0_addr  in  ADDR_WIDTH  master 0 word address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_wstrb  in  DATA_WIDTH/8  master 0 byte strobes; all zero means read.
- m0_rdata  out  DATA_WIDTH  master 0 read data, valid while m0_ready.
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata: same as master 0, for master 1.
- ram_we  out  DATA_WIDTH/8  RAM byte write enables.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_data  out  DATA_WIDTH  RAM write data.
- ram_q  in  DATA_WIDTH  RAM read data, registered by the RAM one cycle after ram_addr.
- conflict_cnt  out  CNT_WIDTH  count of cycles in which both masters requested in IDLE; saturates at all-ones.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, m0_ready=m1_ready=0, ram_we=0, last_grant=1 (so master 0 wins the first tie), wait_cnt=0, conflict_cnt=0. m0_rdata/m1_rdata are combinational from ram_q; their value when not ready is don't-care.
- FSM states: IDLE, ACCESS.
- IDLE:
  - Winner selection is combinational from m0_valid/m1_valid and the policy below.
  - ram_addr, ram_data and ram_we are driven from the winner in the same cycle; ram_we = winner wstrb.
  - If a winner exists: latch grant, update last_grant, go to ACCESS.
  - With no request: ram_we=0 and ram_addr holds the master 0 address.
- ACCESS:
  - Assert the granted master's ready for exactly one cycle; its rdata = ram_q.
  - ram_we forced 0 so a held request is never written twice. ram_addr stays on the granted master.
  - Next state IDLE unconditionally.
- Timing: ready asserts one cycle after valid is sampled in IDLE; peak throughput is one transaction per 2 cycles.
- Loser handling: the losing master's valid stays pending and is re-evaluated in the next IDLE. Worst-case latency is 3 cycles with round-robin, or 2*MAX_WAIT+1 cycles in fixed-priority mode.
- Fixed priority (macro absent):
  - Master 0 wins ties.
  - wait_cnt increments each IDLE cycle in which master 1 loses, and clears when master 1 is granted.
  - When wait_cnt==MAX_WAIT, master 1 wins the next tie.
- conflict_cnt: increments in IDLE when m0_valid && m1_valid, and holds at its maximum value.
- Protocol violation: if a granted master drops valid during ACCESS, ready still pulses and a write already performed is not undone.
- Reset mid-transaction: state returns to IDLE and ready drops immediately (asynchronously); the in-flight write may or may not have committed.
- Address/strobe stability: masters hold addr/wdata/wstrb stable from valid until ready; the arbiter does not register them.

Optional Feature:
- MEM_ARB_ROUND_ROBIN_EN
- Defined: ties are granted to the master that was not last granted, strictly alternating. wait_cnt and MAX_WAIT are unused and optimised out.
- Undefined: fixed priority to master 0 with the MAX_WAIT starvation guard as above.
- All other behaviour is identical in both builds.

Decomposition:
- Package mem_arb_pkg holds the state encoding (IDLE, ACCESS) and the master IDs (M0=0, M1=1).
- One sub-module, mem_arb_pick: purely combinational winner selection from valids, last_grant and wait_cnt, with the policy selected by the macro.
- Muxes and the FSM live in mem_arbiter.

Test Plan:
- Single read: preload RAM[0x10]=0xDEADBEEF; m0 reads 0x10 -> m0_ready 1 cycle after valid, m0_rdata=0xDEADBEEF, m1_ready never asserts.
- Byte write: m1 writes wdata=0x11223344, wstrb=0b0100 to 0x20 (initial 0) -> ram_we=0b0100 for exactly one cycle; a later read returns 0x00220000.
- Held request: m0 holds a write valid through ACCESS -> ram_we is 0 in the ACCESS cycle and exactly one write is observed.
- Fixed priority with MAX_WAIT=4, both masters requesting continuously -> grant sequence M0,M0,M0,M0,M1,M0,…; conflict_cnt increments every IDLE cycle.
- MEM_ARB_ROUND_ROBIN_EN, both masters requesting continuously from reset -> grants M0,M1,M0,M1; each ready spaced 4 cycles apart.
- Reset asserted during ACCESS -> ready drops at once; after release the FSM is in IDLE, conflict_cnt=0, and the next tie goes to M0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master RAM arbiter: FSM state encoding and master IDs.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between two masters.
// MEM_ARB_ROUND_ROBIN_EN selects alternating ties; otherwise fixed priority with a starvation guard.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic              i_m0_valid,
  input  logic              i_m1_valid,
  input  logic              i_last_grant,
  input  logic [WAIT_W-1:0] i_wait_cnt,
  output logic              o_win_valid,
  output logic              o_win_id
);

  logic w_tie_id;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic w_unused_wait;
  assign w_unused_wait = ^i_wait_cnt;
  assign w_tie_id      = ~i_last_grant;
`else
  logic w_unused_last;
  assign w_unused_last = i_last_grant;
  // Master 1 takes the tie only once it has lost MAX_WAIT times in a row.
  assign w_tie_id      = (i_wait_cnt == WAIT_W'(MAX_WAIT)) ? M1 : M0;
`endif

  always_comb begin
    o_win_valid = i_m0_valid | i_m1_valid;
    o_win_id    = M0;
    if (i_m0_valid && i_m1_valid) begin
      o_win_id = w_tie_id;
    end else if (i_m1_valid) begin
      o_win_id = M1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM (1-cycle read latency).
// Build option: define MEM_ARB_ROUND_ROBIN_EN for alternating ties instead of fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    m0_valid,
  output logic                    m0_ready,
  input  logic [ADDR_WIDTH-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_valid,
  output logic                    m1_ready,
  input  logic [ADDR_WIDTH-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic [DATA_WIDTH/8-1:0] ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_data,
  input  logic [DATA_WIDTH-1:0]   ram_q,
  output logic [CNT_WIDTH-1:0]    conflict_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 2);

  state_t               r_state;
  logic                 r_grant;
  logic                 r_last_grant;
  logic [WAIT_W-1:0]    r_wait_cnt;
  logic [CNT_WIDTH-1:0] r_conflict_cnt;
  logic                 r_m0_ready;
  logic                 r_m1_ready;

  logic w_win_valid;
  logic w_win_id;
  logic w_tie;
  logic w_sel;

  mem_arb_pick #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_pick (
    .i_m0_valid   (m0_valid),
    .i_m1_valid   (m1_valid),
    .i_last_grant (r_last_grant),
    .i_wait_cnt   (r_wait_cnt),
    .o_win_valid  (w_win_valid),
    .o_win_id     (w_win_id)
  );

  assign w_tie = m0_valid & m1_valid;

  // IDLE follows the live winner (M0 when nobody asks); ACCESS stays on the latched grant.
  assign w_sel    = (r_state == ACCESS) ? r_grant : w_win_id;
  assign ram_addr = w_sel ? m1_addr  : m0_addr;
  assign ram_data = w_sel ? m1_wdata : m0_wdata;
  assign ram_we   = (rst_n && (r_state == IDLE) && w_win_valid) ?
                    (w_sel ? m1_wstrb : m0_wstrb) : '0;

  assign m0_rdata     = ram_q;
  assign m1_rdata     = ram_q;
  assign m0_ready     = r_m0_ready;
  assign m1_ready     = r_m1_ready;
  assign conflict_cnt = r_conflict_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_grant        <= M0;
      r_last_grant   <= M1;
      r_wait_cnt     <= '0;
      r_conflict_cnt <= '0;
      r_m0_ready     <= 1'b0;
      r_m1_ready     <= 1'b0;
    end else begin
      r_m0_ready <= 1'b0;
      r_m1_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_tie && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
          end
          if (w_win_valid) begin
            r_state      <= ACCESS;
            r_grant      <= w_win_id;
            r_last_grant <= w_win_id;
            r_m0_ready   <= (w_win_id == M0);
            r_m1_ready   <= (w_win_id == M1);
          end
`ifndef MEM_ARB_ROUND_ROBIN_EN
          if (w_win_valid && (w_win_id == M1)) begin
            r_wait_cnt <= '0;
          end else if (w_tie && (r_wait_cnt != WAIT_W'(MAX_WAIT))) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
`endif
        end
        ACCESS:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model with its own memory image.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int MAXW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_valid, m1_valid;
  logic          m0_ready, m1_ready;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [SW-1:0] m0_wstrb, m1_wstrb;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [SW-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] ram_q;
  logic [CW-1:0] conflict_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .MAX_WAIT   (MAXW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_valid     (m0_valid),
    .m0_ready     (m0_ready),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_wstrb     (m0_wstrb),
    .m0_rdata     (m0_rdata),
    .m1_valid     (m1_valid),
    .m1_ready     (m1_ready),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_wstrb     (m1_wstrb),
    .m1_rdata     (m1_rdata),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .ram_q        (ram_q),
    .conflict_cnt (conflict_cnt)
  );

  // Synchronous RAM with byte enables and registered read.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    for (int b = 0; b < SW; b++) begin
      if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_data[8*b +: 8];
    end
    ram_q <= ram[ram_addr];
  end

  int n_pass;
  int n_total;
  int we_cycles;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one pending transaction at most, arbitration decided from the policy rules.
  logic [DW-1:0] mdl_mem [0:(1<<AW)-1];
  bit            mb_busy;
  bit            mb_g;
  bit            mb_read;
  bit            mb_last;
  logic [DW-1:0] mb_rdata;
  int            mb_losses;
  int            mb_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      mb_busy   = 1'b0;
      mb_losses = 0;
      mb_last   = 1'b1;
      mb_cnt    = 0;
      chk("rst_m0_ready", m0_ready, 0);
      chk("rst_m1_ready", m1_ready, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_conflict", conflict_cnt, 0);
    end else begin
      bit            tie;
      bit            wv;
      bit            w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [SW-1:0] s;
      chk("conflict_cnt", conflict_cnt, mb_cnt);
      if (ram_we != '0) we_cycles++;
      if (mb_busy) begin
        chk("m0_ready", m0_ready, !mb_g);
        chk("m1_ready", m1_ready, mb_g);
        if (mb_read) chk("rdata", mb_g ? m1_rdata : m0_rdata, mb_rdata);
        chk("we_access", ram_we, 0);
        chk("addr_access", ram_addr, mb_g ? m1_addr : m0_addr);
        mb_busy = 1'b0;
      end else begin
        chk("m0_ready_idle", m0_ready, 0);
        chk("m1_ready_idle", m1_ready, 0);
        tie = m0_valid && m1_valid;
        wv  = m0_valid || m1_valid;
        if (tie) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          w = !mb_last;
`else
          w = (mb_losses >= MAXW);
`endif
          if (mb_cnt < (1 << CW) - 1) mb_cnt++;
        end else begin
          w = m1_valid;
        end
        chk("addr_idle", ram_addr, (wv && w) ? m1_addr : m0_addr);
        if (wv) begin
          a = w ? m1_addr : m0_addr;
          d = w ? m1_wdata : m0_wdata;
          s = w ? m1_wstrb : m0_wstrb;
          chk("we_idle", ram_we, s);
          if (s != '0) chk("data_idle", ram_data, d);
          mb_busy  = 1'b1;
          mb_g     = w;
          mb_last  = w;
          mb_read  = (s == '0);
          mb_rdata = mdl_mem[a];
          for (int b = 0; b < SW; b++) begin
            if (s[b]) mdl_mem[a][8*b +: 8] = d[8*b +: 8];
          end
          if (w) mb_losses = 0;
          else if (tie) mb_losses++;
        end else begin
          chk("we_none", ram_we, 0);
        end
      end
    end
  end

  task automatic wait_ready(input bit m, output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      seen = m ? m1_ready : m0_ready;
    end
    if (!seen) chk("ready_timeout", 0, 1);
  endtask

  task automatic do_req(input bit m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, output int lat, output logic [DW-1:0] rd);
    if (m) begin
      m1_addr = a; m1_wdata = d; m1_wstrb = s; m1_valid = 1'b1;
    end else begin
      m0_addr = a; m0_wdata = d; m0_wstrb = s; m0_valid = 1'b1;
    end
    wait_ready(m, lat);
    rd = m ? m1_rdata : m0_rdata;
    @(posedge clk); #1;
    if (m) m1_valid = 1'b0;
    else   m0_valid = 1'b0;
  endtask

  task automatic reset_dut();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  int            lat;
  int            wb;
  int            got;
  logic [DW-1:0] rd;
  logic [9:0]    gseq;
  logic [CW-1:0] cnt10;
  bit            ack0, ack1;

  initial begin
    n_pass = 0; n_total = 0; we_cycles = 0;
    m0_valid = 1'b0; m1_valid = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; m0_wstrb = '0; m1_wstrb = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = '0;
      mdl_mem[i] = '0;
    end
    ram[16] = 32'hDEADBEEF;
    mdl_mem[16] = 32'hDEADBEEF;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single read from master 0
    do_req(1'b0, 10'h010, 32'h0, 4'b0000, lat, rd);
    chk("t1_latency", lat, 1);
    chk("t1_rdata", rd, 32'hDEADBEEF);

    // Byte write from master 1, then read back
    wb = we_cycles;
    do_req(1'b1, 10'h020, 32'h11223344, 4'b0100, lat, rd);
    chk("t2_we_cycles", we_cycles - wb, 1);
    do_req(1'b0, 10'h020, 32'h0, 4'b0000, lat, rd);
    chk("t2_readback", rd, 32'h00220000);

    // Held full-word write: one write only
    wb = we_cycles;
    do_req(1'b0, 10'h030, 32'hA5A55A5A, 4'b1111, lat, rd);
    chk("t3_we_cycles", we_cycles - wb, 1);
    do_req(1'b1, 10'h030, 32'h0, 4'b0000, lat, rd);
    chk("t3_readback", rd, 32'hA5A55A5A);

    // Both masters requesting continuously from reset
    reset_dut();
    m0_addr = 10'h010; m0_wstrb = '0; m1_addr = 10'h020; m1_wstrb = '0;
    m0_valid = 1'b1; m1_valid = 1'b1;
    got = 0; gseq = '0; cnt10 = '0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      @(posedge clk); #1;
      if (m0_ready || m1_ready) begin
        gseq[got] = m1_ready;
        if (got == 9) cnt10 = conflict_cnt;
        got++;
      end
    end
    chk("t4_grants", got, 10);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("t4_grant_seq", gseq, 10'h2AA);
`else
    chk("t4_grant_seq", gseq, 10'h210);
`endif
    chk("t4_conflict", cnt10, 10);
    @(posedge clk); #1;
    m0_valid = 1'b0; m1_valid = 1'b0;

    // Reset during ACCESS
    reset_dut();
    m0_valid = 1'b1; m1_valid = 1'b1;
    wait_ready(1'b0, lat);
    chk("t5_first_latency", lat, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_ready_drop", m0_ready, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    chk("t5_conflict_clear", conflict_cnt, 0);
    wait_ready(1'b0, lat);
    chk("t5_tie_to_m0", lat, 1);
    @(posedge clk); #1;
    m0_valid = 1'b0; m1_valid = 1'b0;

    // Randomized traffic on a small address window to force collisions
    ack0 = 1'b0; ack1 = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      if (m0_valid && m0_ready) ack0 = 1'b1;
      else if (!m0_valid || ack0) begin
        ack0 = 1'b0;
        m0_valid = ($urandom_range(0, 2) != 0);
        m0_addr  = AW'($urandom_range(0, 15));
        m0_wdata = $urandom;
        m0_wstrb = ($urandom_range(0, 1) != 0) ? '0 : SW'($urandom_range(0, 15));
      end
      if (m1_valid && m1_ready) ack1 = 1'b1;
      else if (!m1_valid || ack1) begin
        ack1 = 1'b0;
        m1_valid = ($urandom_range(0, 2) != 0);
        m1_addr  = AW'($urandom_range(0, 15));
        m1_wdata = $urandom;
        m1_wstrb = ($urandom_range(0, 1) != 0) ? '0 : SW'($urandom_range(0, 15));
      end
    end
    wait_ready(1'b0, lat);
    m0_valid = 1'b0;
    wait_ready(1'b1, lat);
    m1_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
